// File: rtl/debounce_dual.sv
// rtl/debounce_dual.sv - two-channel button synchroniser, debouncer and edge-pulse generator
//
// Conditions two raw push-button inputs into clean levels plus one-cycle
// rise/fall pulses. Each channel is synchronised through two flops, then
// qualified by a four-state FSM that only accepts a new level after the
// synchronised input has held it for STABLE_TICKS consecutive ticks of a
// shared, free-running prescaler.
//
// Ports:
//   clk     in   system clock, all logic on rising edge
//   rst     in   synchronous, active-high reset
//   btn_a   in   raw asynchronous button A
//   btn_b   in   raw asynchronous button B
//   a       out  debounced level A
//   b       out  debounced level B
//   a_rise  out  one-cycle pulse when a goes 0->1
//   a_fall  out  one-cycle pulse when a goes 1->0
//   b_rise  out  one-cycle pulse when b goes 0->1
//   b_fall  out  one-cycle pulse when b goes 1->0

module debounce_dual #(
  parameter int CLK_DIV      = 1000,
  parameter int DIV_W        = 10,
  parameter int STABLE_TICKS = 10,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_a,
  input  logic btn_b,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  typedef enum logic [1:0] {
    ST_LOW,
    ST_CHK_HI,
    ST_HIGH,
    ST_CHK_LO
  } state_t;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS - 1);

  // Shared prescaler; tick is high for the single cycle at the top of the count.
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Two-flop synchroniser per channel; bit 0 = A, bit 1 = B.
  logic [1:0] sync1;
  logic [1:0] sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_b, btn_a};
      sync2 <= sync1;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             rise_nxt;
    logic             fall_nxt;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;
    logic             s;

    assign s = sync2[ch];

    always_ff @(posedge clk) begin
      if (rst) begin
        state   <= ST_LOW;
        cnt     <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state   <= state_nxt;
        cnt     <= cnt_nxt;
        // Level follows the accepted state: high while HIGH or while
        // checking a possible release.
        level_q <= (state_nxt == ST_HIGH) || (state_nxt == ST_CHK_LO);
        rise_q  <= rise_nxt;
        fall_q  <= fall_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      case (state)
        ST_LOW: begin
          if (s) begin
            state_nxt = ST_CHK_HI;
            cnt_nxt   = '0;
          end
        end
        ST_CHK_HI: begin
          // A bounce back to 0 abandons the check; the next 1 restarts it.
          if (!s) begin
            state_nxt = ST_LOW;
            cnt_nxt   = '0;
          end else if (tick) begin
            if (cnt == CNT_MAX) begin
              state_nxt = ST_HIGH;
              cnt_nxt   = '0;
              rise_nxt  = 1'b1;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        ST_HIGH: begin
          if (!s) begin
            state_nxt = ST_CHK_LO;
            cnt_nxt   = '0;
          end
        end
        ST_CHK_LO: begin
          if (s) begin
            state_nxt = ST_HIGH;
            cnt_nxt   = '0;
          end else if (tick) begin
            if (cnt == CNT_MAX) begin
              state_nxt = ST_LOW;
              cnt_nxt   = '0;
              fall_nxt  = 1'b1;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        default: begin
          state_nxt = ST_LOW;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign a      = g_ch[0].level_q;
  assign a_rise = g_ch[0].rise_q;
  assign a_fall = g_ch[0].fall_q;
  assign b      = g_ch[1].level_q;
  assign b_rise = g_ch[1].rise_q;
  assign b_fall = g_ch[1].fall_q;

endmodule

// File: tb/tb_debounce_dual.sv
// tb/tb_debounce_dual.sv - self-checking bench for debounce_dual

module tb_debounce_dual;

  localparam int ST = 4;
  localparam logic [15:0] MASK = 16'((1 << (ST + 1)) - 1);

  logic clk = 1'b0;
  logic rst, btn_a, btn_b;
  logic a, b, a_rise, a_fall, b_rise, b_fall;
  logic rst2, btn2_a, btn2_b;
  logic a2, b2, a2_rise, a2_fall, b2_rise, b2_fall;

  debounce_dual #(.CLK_DIV(1), .DIV_W(1), .STABLE_TICKS(ST), .CNT_W(2)) u_dut (
    .clk(clk), .rst(rst), .btn_a(btn_a), .btn_b(btn_b),
    .a(a), .b(b), .a_rise(a_rise), .a_fall(a_fall), .b_rise(b_rise), .b_fall(b_fall)
  );

  debounce_dual #(.CLK_DIV(5), .DIV_W(3), .STABLE_TICKS(2), .CNT_W(1)) u_slow (
    .clk(clk), .rst(rst2), .btn_a(btn2_a), .btn_b(btn2_b),
    .a(a2), .b(b2), .a_rise(a2_rise), .a_fall(a2_fall), .b_rise(b2_rise), .b_fall(b2_fall)
  );

  always #5 clk = ~clk;

  logic [5:0] dut_o;
  assign dut_o = {a, b, a_rise, a_fall, b_rise, b_fall};

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: s is the raw input delayed two edges (zeroed by reset);
  // the level flips once the last ST+1 samples of s all disagree with it.
  bit [1:0]  m_d1, m_d2, m_lvl, m_rise, m_fall;
  bit [15:0] m_hist [2];

  function automatic logic [5:0] model_o();
    return {m_lvl[0], m_lvl[1], m_rise[0], m_fall[0], m_rise[1], m_fall[1]};
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
      m_hist[0] = '0; m_hist[1] = '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        bit s, bn;
        bn = (ch == 0) ? btn_a : btn_b;
        s = m_d2[ch];
        m_d2[ch] = m_d1[ch];
        m_d1[ch] = bn;
        m_hist[ch] = {m_hist[ch][14:0], s};
        m_rise[ch] = 1'b0;
        m_fall[ch] = 1'b0;
        if (((m_hist[ch] ^ {16{m_lvl[ch]}}) & MASK) == MASK) begin
          m_lvl[ch] = ~m_lvl[ch];
          if (m_lvl[ch]) m_rise[ch] = 1'b1;
          else           m_fall[ch] = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit       r;
    bit       ba;
    bit       bb;
    bit [5:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input bit r, input bit ba, input bit bb, input bit [5:0] e);
    vec_t v;
    v.r = r; v.ba = ba; v.bb = bb; v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    int ra_cnt, fa_cnt, ra_at, rb_at, lat, exp_lat, off, t1;
    rst = 1'b1; btn_a = 1'b0; btn_b = 1'b0;
    rst2 = 1'b1; btn2_a = 1'b0; btn2_b = 1'b0;

    // Output order: {a, b, a_rise, a_fall, b_rise, b_fall}
    for (int i = 0; i < 5; i++) add_vec(1, 1, 1, 6'b000000);
    for (int i = 5; i < 11; i++) add_vec(0, 1, 0, 6'b000000);
    add_vec(0, 1, 0, 6'b101000);
    add_vec(0, 1, 0, 6'b100000);
    add_vec(0, 1, 0, 6'b100000);
    for (int i = 0; i < 3; i++) add_vec(0, 0, 1, 6'b100000);
    for (int i = 0; i < 3; i++) add_vec(0, 0, 0, 6'b100000);
    add_vec(0, 0, 0, 6'b000100);
    add_vec(0, 0, 0, 6'b000000);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r; btn_a = tbl[i].ba; btn_b = tbl[i].bb;
      step();
      chk($sformatf("vec%0d", i), 32'(dut_o), 32'(tbl[i].exp));
    end

    // Bouncing input: only the final sustained 1 qualifies.
    ra_cnt = 0; fa_cnt = 0; ra_at = -1;
    for (int i = 0; i < 32; i++) begin
      btn_a = (i < 12) ? (((i / 2) % 2) == 0) : 1'b1;
      step();
      if (a_rise) begin ra_cnt++; ra_at = i; end
      if (a_fall) fa_cnt++;
    end
    chk("bounce_rise_count", ra_cnt, 1);
    chk("bounce_rise_edge", ra_at, 18);
    chk("bounce_fall_count", fa_cnt, 0);
    chk("bounce_level", 32'(a), 1);

    // Simultaneous rises on both channels.
    btn_a = 1'b0; btn_b = 1'b0;
    repeat (12) step();
    chk("idle_before_dual", 32'(dut_o), 0);
    ra_at = -1; rb_at = -1;
    for (int i = 0; i < 15; i++) begin
      btn_a = 1'b1; btn_b = 1'b1;
      step();
      if (a_rise && ra_at < 0) ra_at = i;
      if (b_rise && rb_at < 0) rb_at = i;
    end
    chk("dual_a_rise_edge", ra_at, 6);
    chk("dual_b_rise_edge", rb_at, 6);
    chk("dual_same_cycle", 32'(ra_at == rb_at), 1);
    chk("pre_rst_level", 32'({a, b}), 3);

    // Reset while high: outputs clear with no fall pulse.
    rst = 1'b1;
    step();
    chk("rst_while_high", 32'(dut_o), 0);
    rst = 1'b0;
    ra_at = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (a_rise && ra_at < 0) ra_at = i;
    end
    chk("requalify_after_rst", ra_at, 7);

    // Prescaled instance: latency depends on tick phase relative to reset.
    for (int ph = 1; ph <= 5; ph++) begin
      rst2 = 1'b1; btn2_a = 1'b0;
      step();
      rst2 = 1'b0;
      lat = -1;
      for (int e = 1; e <= 30; e++) begin
        btn2_a = (e >= ph);
        step();
        if (a2 && lat < 0) begin
          lat = e - ph;
          chk($sformatf("slow_rise_pulse_ph%0d", ph), 32'(a2_rise), 1);
        end
      end
      off = ph + 2;
      t1 = ((off / 5) + 1) * 5;
      exp_lat = t1 + 5 - ph;
      chk($sformatf("slow_latency_ph%0d", ph), lat, exp_lat);
      chk($sformatf("slow_latency_range_ph%0d", ph), 32'(lat >= 8 && lat <= 12), 1);
    end

    // Random bouncing against the reference model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(5) == 0) btn_a = ~btn_a;
      if ($urandom_range(5) == 0) btn_b = ~btn_b;
      rst = ($urandom_range(299) == 0);
      step();
      chk($sformatf("rand%0d", n), 32'(dut_o), 32'(model_o()));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
